core_link_adapter: RTL

//  Byte<->word bridge between the UART byte engines and the core's 16-bit word interface.
//  RX: packs two received bytes into one word, presents it on data_in/data_in_valid.
//  TX: takes each data_out word, sends it as two bytes, then pulses tx_done back to the core.
//  The core samples on negedge and edge-detects data_in_valid and tx_done.

---
 rtl/core_link_adapter_if.sv | 35 +++
 rtl/core_link_adapter.sv | 201 ++++++++++++++++++++
 2 files changed

// File: rtl/core_link_adapter_if.sv
// core_link_adapter_if: byte/word link bundle between UART engines, core and adapter.
// master = adapter side (drives tx byte, data_in, tx_done, flags); slave = UART/core side.
`timescale 1ns/1ps
interface core_link_adapter_if;
  logic [7:0]  rx_byte;
  logic        rx_byte_valid;
  logic [7:0]  tx_byte;
  logic        tx_byte_start;
  logic        tx_byte_busy;
  logic [15:0] data_in;
  logic        data_in_valid;
  logic [15:0] data_out;
  logic        data_out_valid;
  logic        tx_done;
  logic        err_clr;
  logic        err_rx_overrun;
  logic        err_tx_overrun;
  logic        err_rx_timeout;

  modport master (
    input  rx_byte, rx_byte_valid, tx_byte_busy,
    input  data_out, data_out_valid, err_clr,
    output tx_byte, tx_byte_start,
    output data_in, data_in_valid, tx_done,
    output err_rx_overrun, err_tx_overrun, err_rx_timeout
  );

  modport slave (
    output rx_byte, rx_byte_valid, tx_byte_busy,
    output data_out, data_out_valid, err_clr,
    input  tx_byte, tx_byte_start,
    input  data_in, data_in_valid, tx_done,
    input  err_rx_overrun, err_tx_overrun, err_rx_timeout
  );
endinterface

// File: rtl/core_link_adapter.sv
// core_link_adapter: packs UART RX byte pairs into 16-bit words for the core and
// splits core words into two UART TX bytes.
// Ports: clk, rstb (async active-low), lnk (core_link_adapter_if.master):
//   rx_byte/rx_byte_valid in, tx_byte/tx_byte_start out, tx_byte_busy in,
//   data_in/data_in_valid out, data_out/data_out_valid in, tx_done out,
//   err_clr in, err_rx_overrun/err_tx_overrun/err_rx_timeout out (sticky).
// data_in_valid and tx_done are stretched to VALID_HOLD cycles with an
// equal low gap, because the core samples on negedge and edge-detects them.
`timescale 1ns/1ps
module core_link_adapter #(
  parameter int HI_FIRST   = 1,
  parameter int VALID_HOLD = 2,
  parameter int RX_TIMEOUT = 4096
) (
  input  logic clk,
  input  logic rstb,
  core_link_adapter_if.master lnk
);

  localparam int TW = (RX_TIMEOUT > 0) ?
                      $clog2(RX_TIMEOUT + 1) : 1;
  localparam int HW = $clog2(2 * VALID_HOLD + 1);
  localparam logic [TW-1:0] TLAST = TW'(RX_TIMEOUT - 1);
  localparam logic [HW-1:0] H1 = HW'(VALID_HOLD - 1);
  localparam logic [HW-1:0] H2 = HW'(2 * VALID_HOLD - 1);

  typedef enum logic [1:0] {
    RX_HI, RX_LO, RX_PRESENT, RX_GAP
  } rx_st_t;

  typedef enum logic [2:0] {
    TX_IDLE, TX_B0, TX_W0, TX_B1, TX_W1, TX_DONE
  } tx_st_t;

  rx_st_t rx_st;
  tx_st_t tx_st;

  logic [7:0]    first;
  logic [TW-1:0] timer;
  logic [HW-1:0] rcnt;
  logic [15:0]   din_q;
  logic          dval_q;
  logic          e_rxo;
  logic          e_rxt;

  logic [15:0]   word;
  logic [7:0]    txb_q;
  logic          start_q;
  logic          done_q;
  logic [HW-1:0] tcnt;
  logic          skip;
  logic          e_txo;

  logic [15:0]   rx_word;
  logic [7:0]    b0;
  logic [7:0]    b1;

  assign rx_word = (HI_FIRST != 0) ?
                   {first, lnk.rx_byte} :
                   {lnk.rx_byte, first};
  assign b0 = (HI_FIRST != 0) ? word[15:8] : word[7:0];
  assign b1 = (HI_FIRST != 0) ? word[7:0]  : word[15:8];

  // RX: set beats clear because the set is written last.
  always_ff @(posedge clk or negedge rstb) begin
    if (!rstb) begin
      rx_st  <= RX_HI;
      first  <= '0;
      timer  <= '0;
      rcnt   <= '0;
      din_q  <= '0;
      dval_q <= 1'b0;
      e_rxo  <= 1'b0;
      e_rxt  <= 1'b0;
    end else begin
      if (lnk.err_clr) begin
        e_rxo <= 1'b0;
        e_rxt <= 1'b0;
      end
      unique case (rx_st)
        RX_HI: begin
          if (lnk.rx_byte_valid) begin
            first <= lnk.rx_byte;
            timer <= '0;
            rx_st <= RX_LO;
          end
        end
        RX_LO: begin
          if (lnk.rx_byte_valid) begin
            din_q  <= rx_word;
            dval_q <= 1'b1;
            rcnt   <= '0;
            rx_st  <= RX_PRESENT;
          end else if (RX_TIMEOUT != 0 &&
                       timer == TLAST) begin
            e_rxt <= 1'b1;
            timer <= '0;
            rx_st <= RX_HI;
          end else if (timer != '1) begin
            timer <= timer + 1'b1;
          end
        end
        RX_PRESENT: begin
          if (lnk.rx_byte_valid) e_rxo <= 1'b1;
          if (rcnt == H1) begin
            dval_q <= 1'b0;
            rx_st  <= RX_GAP;
          end
          rcnt <= rcnt + 1'b1;
        end
        RX_GAP: begin
          if (lnk.rx_byte_valid) e_rxo <= 1'b1;
          if (rcnt == H2) begin
            rcnt  <= '0;
            rx_st <= RX_HI;
          end else begin
            rcnt <= rcnt + 1'b1;
          end
        end
        default: rx_st <= RX_HI;
      endcase
    end
  end

  // TX: the first W cycle ignores busy, since the
  // UART only raises it the cycle after start.
  always_ff @(posedge clk or negedge rstb) begin
    if (!rstb) begin
      tx_st   <= TX_IDLE;
      word    <= '0;
      txb_q   <= '0;
      start_q <= 1'b0;
      done_q  <= 1'b0;
      tcnt    <= '0;
      skip    <= 1'b0;
      e_txo   <= 1'b0;
    end else begin
      start_q <= 1'b0;
      if (lnk.err_clr) e_txo <= 1'b0;
      if (lnk.data_out_valid && tx_st != TX_IDLE)
        e_txo <= 1'b1;
      unique case (tx_st)
        TX_IDLE: begin
          if (lnk.data_out_valid) begin
            word  <= lnk.data_out;
            tx_st <= TX_B0;
          end
        end
        TX_B0: begin
          if (!lnk.tx_byte_busy) begin
            txb_q   <= b0;
            start_q <= 1'b1;
            skip    <= 1'b1;
            tx_st   <= TX_W0;
          end
        end
        TX_W0: begin
          if (skip) skip <= 1'b0;
          else if (!lnk.tx_byte_busy) tx_st <= TX_B1;
        end
        TX_B1: begin
          if (!lnk.tx_byte_busy) begin
            txb_q   <= b1;
            start_q <= 1'b1;
            skip    <= 1'b1;
            tx_st   <= TX_W1;
          end
        end
        TX_W1: begin
          if (skip) begin
            skip <= 1'b0;
          end else if (!lnk.tx_byte_busy) begin
            done_q <= 1'b1;
            tcnt   <= '0;
            tx_st  <= TX_DONE;
          end
        end
        TX_DONE: begin
          if (tcnt == H1) done_q <= 1'b0;
          if (tcnt == H2) begin
            tcnt  <= '0;
            tx_st <= TX_IDLE;
          end else begin
            tcnt <= tcnt + 1'b1;
          end
        end
        default: tx_st <= TX_IDLE;
      endcase
    end
  end

  assign lnk.data_in        = din_q;
  assign lnk.data_in_valid  = dval_q;
  assign lnk.tx_byte        = txb_q;
  assign lnk.tx_byte_start  = start_q;
  assign lnk.tx_done        = done_q;
  assign lnk.err_rx_overrun = e_rxo;
  assign lnk.err_tx_overrun = e_txo;
  assign lnk.err_rx_timeout = e_rxt;

endmodule
